demux14_stream: RTL and testbench

// - Registered 1-to-4 demultiplexer, the inverse of the ALU32 4:1 result mux.
// - Routes one WIDTH-bit word plus a 2-bit select to one of four downstream consumers.
// - Consumers are ALU32 operand latches or register-file write ports; each has its own valid/ready.
// - Single output register stage: full throughput, no bubbles while the target consumer is ready.

---
 rtl/demux_pkg.sv | 14 +
 rtl/demux14_stream_dec24.sv | 20 ++
 rtl/demux14_stream.sv | 98 +++++++++
 tb/tb_demux14_stream.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and constants for the 1-to-4 stream demultiplexer
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } dmx_state_t;

    typedef logic [SEL_W-1:0] ch_sel_t;

endpackage

// File: rtl/demux14_stream_dec24.sv
// rtl/demux14_stream_dec24.sv - enabled 2-to-4 one-hot decoder (module dec24)
module dec24
    import demux_pkg::*;
(
    input  logic              en,
    input  ch_sel_t           sel,
    output logic [NUM_CH-1:0] onehot
);

    // One bit per channel; all zero when disabled so at most one bit is ever set.
    always_comb begin
        onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (en && (sel == ch_sel_t'(k))) begin
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux14_stream.sv
// rtl/demux14_stream.sv - registered 1-to-4 demux; DEMUX_STATS_EN adds per-channel drain counters
module demux14_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
`ifdef DEMUX_STATS_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  ch_sel_t               in_sel,
    output logic [NUM_CH-1:0]     out_valid,
    input  logic [NUM_CH-1:0]     out_ready,
    output logic [WIDTH-1:0]      out_data,
    output ch_sel_t               out_sel
`ifdef DEMUX_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] stat_cnt
`endif
);

    dmx_state_t        state_q;
    dmx_state_t        state_d;
    logic              accept;
    logic              drain;
    logic              load;
    logic [NUM_CH-1:0] drain_vec;

    // The same decode drives out_valid and, masked by out_ready, the per-channel drain strobes.
    dec24 u_dec (
        .en     (state_q == FULL),
        .sel    (out_sel),
        .onehot (out_valid)
    );

    // Only the selected channel's ready can matter because out_valid is one-hot.
    assign drain_vec = out_valid & out_ready;
    assign drain     = |drain_vec;

    // Ready is forced low during reset; otherwise free slot or slot being emptied this cycle.
    assign in_ready  = rst_n & ((state_q == EMPTY) | drain);
    assign accept    = in_valid & in_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and load strobe: accepting always lands in FULL, a bare drain empties.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        if (accept) begin
            state_d = FULL;
            load    = 1'b1;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    // Output data/select register; holds its value until a new word is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_sel  <= '0;
        end else if (load) begin
            out_data <= in_data;
            out_sel  <= in_sel;
        end
    end

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_stat
        // Per-channel drain counter, wraps naturally at 2**CNT_W.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[k] <= '0;
            end else if (drain_vec[k]) begin
                cnt_q[k] <= cnt_q[k] + 1'b1;
            end
        end

        assign stat_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_demux14_stream.sv
// tb/tb_demux14_stream.sv - directed self-checking bench for demux14_stream (DEMUX_STATS_EN aware)
module tb_demux14_stream;
    import demux_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    ch_sel_t     in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    ch_sel_t     out_sel;
`ifdef DEMUX_STATS_EN
    logic [31:0] stat_cnt;
`endif

    int total;
    int bad;

    demux14_stream #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
`ifdef DEMUX_STATS_EN
        ,
        .stat_cnt  (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = 4'b0000;

        // reset state
        edge_step();
        edge_step();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_sel", out_sel, 2'd0);
`ifdef DEMUX_STATS_EN
        chk("rst_stat", stat_cnt, 32'h0);
`endif
        edge_step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 4'b0000);

        // single word to channel 3
        edge_step();
        in_valid  = 1'b1;
        in_data   = 32'hDEADBEEF;
        in_sel    = 2'd3;
        out_ready = 4'b1000;
        @(negedge clk);
        chk("single_in_ready", in_ready, 1'b1);
        edge_step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("single_out_valid", out_valid, 4'b1000);
        chk("single_out_data", out_data, 32'hDEADBEEF);
        chk("single_out_sel", out_sel, 2'd3);
        chk("single_in_ready_drain", in_ready, 1'b1);
        edge_step();
        @(negedge clk);
        chk("single_empty", out_valid, 4'b0000);

        // back-to-back across all channels
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_sel   = ch_sel_t'(i);
            in_data  = 32'(i + 1);
            @(negedge clk);
            chk("b2b_in_ready", in_ready, 1'b1);
            if (i > 0) begin
                chk("b2b_out_valid", out_valid, 4'b0001 << (i - 1));
                chk("b2b_out_data", out_data, 32'(i));
            end
            edge_step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_valid", out_valid, 4'b1000);
        chk("b2b_last_data", out_data, 32'd4);
        edge_step();
        @(negedge clk);
        chk("b2b_empty", out_valid, 4'b0000);

        // stall on channel 1 with other channels ready
        out_ready = 4'b1101;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 32'hA5A50001;
        edge_step();
        in_sel  = 2'd2;
        in_data = 32'h00000002;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 4'b0010);
            chk("stall_out_data", out_data, 32'hA5A50001);
            edge_step();
        end
        out_ready = 4'b1111;
        @(negedge clk);
        chk("stall_release_ready", in_ready, 1'b1);
        edge_step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall_next_valid", out_valid, 4'b0100);
        chk("stall_next_data", out_data, 32'h00000002);
        edge_step();
        @(negedge clk);
        chk("stall_empty", out_valid, 4'b0000);

        // ready on the wrong channels only
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 32'h00000011;
        edge_step();
        in_valid  = 1'b0;
        out_ready = 4'b1110;
        @(negedge clk);
        chk("wrong_in_ready", in_ready, 1'b0);
        chk("wrong_out_valid", out_valid, 4'b0001);
        edge_step();
        @(negedge clk);
        chk("wrong_hold_valid", out_valid, 4'b0001);
        chk("wrong_hold_data", out_data, 32'h00000011);
        out_ready = 4'b0001;
        edge_step();
        @(negedge clk);
        chk("wrong_drained", out_valid, 4'b0000);

        // reset while holding a word for channel 2
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 32'h00000022;
        edge_step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_full", out_valid, 4'b0100);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 4'b0000);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_out_data", out_data, 32'h0);
        edge_step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_after_valid", out_valid, 4'b0000);
        chk("midrst_after_ready", in_ready, 1'b1);

`ifdef DEMUX_STATS_EN
        // 257 drains on channel 2 wrap its 8-bit counter to 1
        chk("stat_cleared", stat_cnt, 32'h0);
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 32'h0000CAFE;
        for (int i = 0; i < 257; i++) begin
            edge_step();
        end
        in_valid = 1'b0;
        edge_step();
        @(negedge clk);
        chk("stat_empty", out_valid, 4'b0000);
        chk("stat_wrap", stat_cnt, 32'h00010000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
